serial_compare_ctrl: RTL and testbench
======================================

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  clock; all state changes on rising edge.
REQ-002 SHALL provide: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: start  input  1  request to compare a and b; sampled only in IDLE.
REQ-004 SHALL provide: a  input  32  unsigned operand A; sampled on the accepting edge only.
REQ-005 SHALL provide: b  input  32  unsigned operand B; sampled on the accepting edge only.
REQ-006 SHALL provide: busy  output  1  high while a comparison is in progress (state SHIFT).
REQ-007 SHALL provide: done  output  1  one-cycle pulse marking valid results.
REQ-008 SHALL provide: gt, eq, lt  output  1 each  A>B, A==B, A<B; one-hot when valid.
REQ-009 SHALL provide: cycles  output  6  number of bit-compare cycles used by the last comparison.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; registered outputs only.
REQ-011 IDLE: start=1 at edge E0 SHALL load a, b into internal 32-bit left-shift registers, clear the bit counter, clear gt/eq/lt/cycles to 0, and enter SHIFT.
REQ-012 SHIFT: each edge E1..E32 SHALL compare the current MSBs of both shift registers (bit 31 first, bit 0 last), then shift both left by one, zero-filling the LSB.
REQ-013 The first differing bit pair SHALL fix the decision (A bit 1 -> gt, B bit 1 -> lt); later bits SHALL NOT alter it.
REQ-014 At the final compare edge, the FSM SHALL enter DONE, set done=1, drive gt/eq/lt (eq=1 if no differing bit), and set cycles to the compare count.
REQ-015 DONE SHALL last exactly one cycle, then return to IDLE with done=0.
REQ-016 gt/eq/lt/cycles SHALL hold their values from DONE until the next accepted start.
REQ-017 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-018 Minimum start-to-start spacing SHALL be start at E0, next accepted at E(n+2), where n = compare cycles.
REQ-019 a/b changes after E0 SHALL have no effect on the in-flight comparison.
REQ-020 Comparison SHALL be unsigned; no sign interpretation of bit 31.

Reset
REQ-021 reset=1 SHALL force IDLE, busy=0, done=0, gt=eq=lt=0, cycles=0, clear shift registers and counter.
REQ-022 reset SHALL take priority over start on the same edge.
REQ-023 reset mid-SHIFT SHALL abort the comparison with no done pulse.

Configuration
REQ-024 Macro SERIAL_CMP_EARLY_EXIT_EN SHALL control early termination.
REQ-025 Defined: FSM SHALL enter DONE on the edge that compares the first differing bit pair (n = 1..32); equal operands still take 32.
REQ-026 Not defined: FSM SHALL always perform exactly 32 compare cycles (n = 32, cycles = 32).

Verification
REQ-027 a=0x00000005, b=0x00000003, start at E0 -> done at E32, gt=1, eq=lt=0, cycles=32 (no macro).
REQ-028 a=b=0xFFFFFFFF -> done at E32, eq=1, cycles=32 (both configurations).
REQ-029 a=0x80000000, b=0x7FFFFFFF -> gt=1; with macro done at E1, cycles=1; without, done at E32.
REQ-030 a=0x00000010, b=0x00000011 -> lt=1; with macro done at E32, cycles=32 (first difference at bit 0).
REQ-031 start pulsed at E5 with new operands during SHIFT -> ignored; result matches E0 operands; busy stays 1.
REQ-032 reset asserted at E10 of a comparison -> next cycle busy=0, done never pulses, gt=eq=lt=0, cycles=0; fresh start accepted afterward.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator: MSB-first over 32 cycles with registered results.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit pair.
module serial_compare_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        gt_o,
    output logic        eq_o,
    output logic        lt_o,
    output logic [5:0]  cycles_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q;
    logic [31:0] sa_q, sb_q;
    logic [5:0]  cnt_q;
    logic        dec_gt_q, dec_lt_q;

    logic        nxt_gt, nxt_lt, last_cmp;
    logic [5:0]  cnt_inc;

    // Once either decision flag is set, later bit pairs cannot change it.
    always_comb begin
        cnt_inc = cnt_q + 6'd1;
        nxt_gt  = dec_gt_q | (~dec_gt_q & ~dec_lt_q & sa_q[31] & ~sb_q[31]);
        nxt_lt  = dec_lt_q | (~dec_gt_q & ~dec_lt_q & ~sa_q[31] & sb_q[31]);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        last_cmp = (cnt_q == 6'd31) || nxt_gt || nxt_lt;
`else
        last_cmp = (cnt_q == 6'd31);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            dec_gt_q <= 1'b0;
            dec_lt_q <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            gt_o     <= 1'b0;
            eq_o     <= 1'b0;
            lt_o     <= 1'b0;
            cycles_o <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        sa_q     <= a_i;
                        sb_q     <= b_i;
                        cnt_q    <= '0;
                        dec_gt_q <= 1'b0;
                        dec_lt_q <= 1'b0;
                        gt_o     <= 1'b0;
                        eq_o     <= 1'b0;
                        lt_o     <= 1'b0;
                        cycles_o <= '0;
                        busy_o   <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    sa_q     <= {sa_q[30:0], 1'b0};
                    sb_q     <= {sb_q[30:0], 1'b0};
                    cnt_q    <= cnt_inc;
                    dec_gt_q <= nxt_gt;
                    dec_lt_q <= nxt_lt;
                    if (last_cmp) begin
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        gt_o     <= nxt_gt;
                        lt_o     <= nxt_lt;
                        eq_o     <= ~(nxt_gt | nxt_lt);
                        cycles_o <= cnt_inc;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed self-checking bench for serial_compare_ctrl; follows SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_compare_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start_i;
    logic [31:0] a_i, b_i;
    logic        busy_o, done_o, gt_o, eq_o, lt_o;
    logic [5:0]  cycles_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .gt_o     (gt_o),
        .eq_o     (eq_o),
        .lt_o     (lt_o),
        .cycles_o (cycles_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({busy_o, done_o, gt_o, eq_o, lt_o, cycles_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %b, want 0", {busy_o, done_o, gt_o, eq_o, lt_o, cycles_o});
        end
    endtask

    // Starts at posedge+1 in IDLE, ends at posedge+1 back in IDLE.
    task automatic test_compare(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] exp_res, input int n_early);
        int n, k;
        bit seen;
        n = Early ? n_early : 32;
        start_i = 1'b1; a_i = a; b_i = b;
        step();
        start_i = 1'b0; a_i = ~a; b_i = ~b;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_o);
        end
        checks++;
        if ({gt_o, eq_o, lt_o, cycles_o} !== 9'd0) begin
            errors++;
            $display("FAIL %s clear_on_start: got %b want 0", name, {gt_o, eq_o, lt_o, cycles_o});
        end
        seen = 0; k = 0;
        while (!seen && k < 40) begin
            step(); k++;
            if (done_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || k != n) begin
            errors++; $display("FAIL %s done_latency: got %0d (seen=%0d) want %0d", name, k, seen, n);
        end
        checks++;
        if ({gt_o, eq_o, lt_o} !== exp_res) begin
            errors++; $display("FAIL %s result: got %b want %b", name, {gt_o, eq_o, lt_o}, exp_res);
        end
        checks++;
        if (cycles_o !== 6'(n)) begin
            errors++; $display("FAIL %s cycles: got %0d want %0d", name, cycles_o, n);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy_o);
        end
        step();
        checks++;
        if ({done_o, gt_o, eq_o, lt_o, cycles_o} !== {1'b0, exp_res, 6'(n)}) begin
            errors++;
            $display("FAIL %s hold_after_done: got %b want %b", name,
                     {done_o, gt_o, eq_o, lt_o, cycles_o}, {1'b0, exp_res, 6'(n)});
        end
    endtask

    task automatic test_vectors();
        test_compare("five_vs_three", 32'h0000_0005, 32'h0000_0003, 3'b100, 30);
        test_compare("all_ones_eq",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 32);
        test_compare("unsigned_msb",  32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1);
        test_compare("lsb_differs",   32'h0000_0010, 32'h0000_0011, 3'b001, 32);
        test_compare("bit17_lt",      32'h0001_0000, 32'h0002_0000, 3'b001, 15);
        test_compare("zero_eq",       32'h0000_0000, 32'h0000_0000, 3'b010, 32);
    endtask

    task automatic test_start_ignored();
        int k, n;
        bit seen;
        n = Early ? 30 : 32;
        start_i = 1'b1; a_i = 32'd5; b_i = 32'd3;
        step();
        start_i = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        start_i = 1'b1; a_i = 32'd3; b_i = 32'd5;
        step();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL ignored_start_busy: got %b want 1", busy_o);
        end
        seen = 0; k = 5;
        while (!seen && k < 45) begin
            step(); k++;
            if (done_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || k != n || {gt_o, eq_o, lt_o} !== 3'b100) begin
            errors++;
            $display("FAIL ignored_start_result: got edge %0d res %b want edge %0d res 100",
                     k, {gt_o, eq_o, lt_o}, n);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses;
        start_i = 1'b1; a_i = 32'hA5A5_A5A5; b_i = 32'hA5A5_A5A5;
        step();
        start_i = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({busy_o, done_o, gt_o, eq_o, lt_o, cycles_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_state: got %b want 0", {busy_o, done_o, gt_o, eq_o, lt_o, cycles_o});
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_o !== 1'b0 || busy_o !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", pulses);
        end
        test_compare("after_reset", 32'h0000_0001, 32'h0000_0000, 3'b100, 32);
    endtask

    task automatic test_reset_priority();
        start_i = 1'b1; reset = 1'b1; a_i = 32'd1; b_i = 32'd2;
        step();
        start_i = 1'b0; reset = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_priority: got busy %b want 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int k, n;
        bit seen;
        n = Early ? 31 : 32;
        start_i = 1'b1; a_i = 32'd1; b_i = 32'd2;
        step();
        seen = 0; k = 0;
        while (!seen && k < 40) begin
            step(); k++;
            if (done_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || k != n || {gt_o, eq_o, lt_o} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_first: got edge %0d res %b want edge %0d res 001", k, {gt_o, eq_o, lt_o}, n);
        end
        step();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL b2b_done_ignores_start: got busy %b done %b want 0 0", busy_o, done_o);
        end
        step();
        checks++;
        if (busy_o !== 1'b1 || {gt_o, eq_o, lt_o} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_second_accept: got busy %b res %b want 1 000", busy_o, {gt_o, eq_o, lt_o});
        end
        start_i = 1'b0;
        seen = 0; k = 0;
        while (!seen && k < 40) begin
            step(); k++;
            if (done_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || k != n || {gt_o, eq_o, lt_o} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_second: got edge %0d res %b want edge %0d res 001", k, {gt_o, eq_o, lt_o}, n);
        end
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_reset_mid();
        test_reset_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
